pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2, number of pipeline stages; SHALL be >= 1 and SHALL divide WIDTH evenly.
REQ-003 clk  input  1  clock; the block SHALL use this one clock, with all state updated on the rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 cin  input  1  carry-in.
REQ-008 in_valid  input  1  operands valid this cycle.
REQ-009 in_ready  output  1  block accepts operands this cycle.
REQ-010 sum  output  WIDTH  result bits.
REQ-011 cout  output  1  carry-out of result MSB.
REQ-012 out_valid  output  1  sum/cout hold a valid result.
REQ-013 out_ready  input  1  consumer accepts result this cycle.

Function
REQ-014 Operand transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1; result transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-015 Arithmetic: {cout,sum} SHALL equal a + b + cin, computed modulo 2^(WIDTH+1), with no saturation.
REQ-016 Each stage SHALL add one WIDTH/STAGES-bit slice, LSB slice first, and pass its registered carry to the next stage.
REQ-017 Unconsumed upper operand slices SHALL be registered alongside each stage.
REQ-018 Lower result slices SHALL be registered alongside each stage.
REQ-019 Latency: a result SHALL be visible with out_valid=1 exactly STAGES cycles after its operand transfer when no stall occurs.
REQ-020 Throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-021 Stall: in_ready SHALL equal (out_valid==0) OR (out_ready==1), combinationally.
REQ-022 When in_ready=0, all stage registers, including per-stage valid bits, SHALL hold.
REQ-023 Bubbles: when in_ready=1 and in_valid=0, a stage-0 valid bit of 0 SHALL enter the pipe.
REQ-024 Bubble-stage data SHALL be don't-care, but the output SHALL never assert out_valid for a bubble.
REQ-025 While out_valid=1 and out_ready=0, sum and cout SHALL be held stable.
REQ-026 Operand order SHALL be preserved: results SHALL emerge in acceptance order with none dropped or duplicated.
REQ-027 Boundaries: all-ones + all-ones + 1 SHALL yield sum=all-ones, cout=1.
REQ-028 Boundaries: 0+0+0 SHALL yield sum=0, cout=0.
REQ-029 Boundaries: a carry rippling across every slice boundary SHALL resolve correctly.

Reset
REQ-030 rst=0 SHALL immediately clear all per-stage valid bits and out_valid, independent of clk.
REQ-031 During reset sum=0 and cout=0.
REQ-032 Reset mid-operation SHALL discard all in-flight results.
REQ-033 The first accepted operand after rst rises SHALL appear after exactly STAGES cycles.
REQ-034 in_ready SHALL be 1 during and after reset, because out_valid=0.

Configuration
REQ-035 Macro PIPELINED_ADDER_SUB_EN: when defined, SHALL add input port sub (1 bit), sampled with the operands.
REQ-036 With PIPELINED_ADDER_SUB_EN defined and sub=1, the result SHALL be a + ~b + 1, with cin ignored and cout meaning "no borrow".
REQ-037 With PIPELINED_ADDER_SUB_EN defined and sub=0, behaviour SHALL match REQ-015.
REQ-038 Without PIPELINED_ADDER_SUB_EN, no sub port SHALL exist and the block SHALL add only.

Structure
REQ-039 Shared package adder_pkg SHALL hold the default constants ADDER_WIDTH=8 and ADDER_STAGES=2.
REQ-040 adder_pkg SHALL hold the slice-width function WIDTH/STAGES.
REQ-041 A sub-module adder_slice (parametrised slice width, combinational slice sum plus carry-out) SHALL be instantiated once per stage.
REQ-042 The pipeline registers SHALL reside in pipelined_adder.

Verification
REQ-043 WIDTH=8, STAGES=2: a=8'd200, b=8'd100, cin=0, out_ready=1 -> 2 cycles later sum=8'd44, cout=1, out_valid=1 for one cycle.
REQ-044 Back-to-back a=1..10, b=1, cin=1, out_ready=1 -> sums 3..12 on 10 consecutive cycles, in order.
REQ-045 Stall: issue 3 operands, hold out_ready=0 for 5 cycles -> in_ready=0, sum stable, no loss; release -> 3 results in order.
REQ-046 Carry ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; repeat with STAGES=4 and STAGES=8.
REQ-047 Reset with 2 results in flight: assert rst=0 mid-cycle -> out_valid falls without a clock edge; no stale result after release.
REQ-048 With PIPELINED_ADDER_SUB_EN: a=8'd5, b=8'd7, sub=1 -> sum=8'd254, cout=0; a=8'd7, b=8'd5, sub=1 -> sum=8'd2, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH  = 8;
    localparam int unsigned ADDER_STAGES = 2;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit adder slice with carry in/out.
module adder_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined ripple adder, one WIDTH/STAGES-bit slice per stage.
// Optional subtract mode via macro PIPELINED_ADDER_SUB_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = ADDER_WIDTH,
    parameter int unsigned STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             adv;

`ifdef PIPELINED_ADDER_SUB_EN
    // a - b as a + ~b + 1; cout then reads as "no borrow"
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Whole pipe advances together; a stalled output freezes every stage
    assign adv = in_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned InW = WIDTH - s * SW;

        logic [InW-1:0]        in_a;
        logic [InW-1:0]        in_b;
        logic                  in_c;
        logic                  in_v;
        logic [SW-1:0]         slice_sum;
        logic                  slice_cout;
        logic [(s+1)*SW-1:0]   res_d;
        logic [(s+1)*SW-1:0]   res_q;
        logic                  c_q;
        logic                  v_q;

        if (s == 0) begin : g_src
            assign in_a  = a;
            assign in_b  = b_eff;
            assign in_c  = cin_eff;
            assign in_v  = in_valid;
            assign res_d = slice_sum;
        end else begin : g_src
            assign in_a  = g_stage[s-1].g_fwd.a_q;
            assign in_b  = g_stage[s-1].g_fwd.b_q;
            assign in_c  = g_stage[s-1].c_q;
            assign in_v  = g_stage[s-1].v_q;
            assign res_d = {slice_sum, g_stage[s-1].res_q};
        end

        adder_slice #(
            .SW (SW)
        ) u_slice (
            .a    (in_a[SW-1:0]),
            .b    (in_b[SW-1:0]),
            .cin  (in_c),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                res_q <= '0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
            end else if (adv) begin
                res_q <= res_d;
                c_q   <= slice_cout;
                v_q   <= in_v;
            end
        end

        // Carry the not-yet-added upper operand slices to the next stage
        if (s < STAGES - 1) begin : g_fwd
            logic [InW-SW-1:0] a_q;
            logic [InW-SW-1:0] b_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= in_a[InW-1:SW];
                    b_q <= in_b[InW-1:SW];
                end
            end
        end
    end

    assign sum       = g_stage[STAGES-1].res_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign in_ready  = !out_valid || out_ready;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: vector table, directed handshake
// sequences and a random stream against a fixed-latency reference model.
module tb_pipelined_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned ST = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         cin, in_valid, out_ready, sub;
    logic         in_ready, out_valid, cout;
    logic [W-1:0] sum;
    logic         in_ready4, out_valid4, cout4;
    logic [W-1:0] sum4;
    logic         in_ready8, out_valid8, cout8;
    logic [W-1:0] sum8;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .in_valid(in_valid), .in_ready(in_ready4), .sum(sum4), .cout(cout4),
        .out_valid(out_valid4), .out_ready(out_ready)
    );

    pipelined_adder #(.WIDTH(W), .STAGES(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .in_valid(in_valid), .in_ready(in_ready8), .sum(sum8), .cout(cout8),
        .out_valid(out_valid8), .out_ready(out_ready)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference: results emerge ST cycles after acceptance; the pipe moves
    // only when its last slot is empty or being consumed.
    logic       m_v [ST];
    logic [W:0] m_r [ST];
    logic [W:0] got_q [$];
    logic       obs_v, obs_rdy, obs_cout, o4_v, o8_v;
    logic [W-1:0] obs_sum;
    logic [W:0] o4_r, o8_r;

    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ST; i++) begin
            m_v[i] = 1'b0;
            m_r[i] = '0;
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, input logic rdy);
        logic exp_v, exp_rdy;
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = c;
        out_ready = rdy;
        @(negedge clk);
        exp_v   = m_v[ST-1];
        exp_rdy = !exp_v || rdy;
        obs_v   = out_valid;
        obs_rdy = in_ready;
        obs_sum = sum;
        obs_cout = cout;
        o4_v = out_valid4;
        o4_r = {cout4, sum4};
        o8_v = out_valid8;
        o8_r = {cout8, sum8};
        check("out_valid", {15'd0, out_valid}, {15'd0, exp_v});
        check("in_ready", {15'd0, in_ready}, {15'd0, exp_rdy});
        if (exp_v) check("result", {7'd0, cout, sum}, {7'd0, m_r[ST-1]});
        if (out_valid && rdy) got_q.push_back({cout, sum});
        if (exp_rdy) begin
            for (int i = ST - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_r[i] = m_r[i-1];
            end
            m_v[0] = v;
            m_r[0] = ref_result(av, bv, c, sub);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1};
        vecs[1] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1};
        vecs[2] = '{8'h00,  8'h00,  1'b0, 8'h00,  1'b0};
        vecs[3] = '{8'h0F,  8'h01,  1'b0, 8'h10,  1'b0};
        vecs[4] = '{8'hFF,  8'h00,  1'b1, 8'h00,  1'b1};
        vecs[5] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1};
        vecs[6] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0};
        vecs[7] = '{8'h55,  8'hAA,  1'b0, 8'hFF,  1'b0};

        rst = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        model_reset();
        #2;
        check("reset out_valid", {15'd0, out_valid}, 16'd0);
        check("reset in_ready", {15'd0, in_ready}, 16'd1);
        check("reset sum", {8'd0, sum}, 16'd0);
        check("reset cout", {15'd0, cout}, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Vector table: exact latency and one-cycle out_valid
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b1);
            for (int k = 1; k <= ST + 1; k++) begin
                step(1'b0, '0, '0, 1'b0, 1'b1);
                if (k == ST - 1) check("vec early valid", {15'd0, obs_v}, 16'd0);
                if (k == ST) begin
                    check("vec valid", {15'd0, obs_v}, 16'd1);
                    check("vec sum", {8'd0, obs_sum}, {8'd0, vecs[i].es});
                    check("vec cout", {15'd0, obs_cout}, {15'd0, vecs[i].ec});
                end
                if (k == ST + 1) check("vec valid drop", {15'd0, obs_v}, 16'd0);
            end
        end

        // Back-to-back throughput
        got_q.delete();
        for (int c = 0; c < 10 + ST; c++) begin
            step(c < 10, W'(c + 1), 8'd1, 1'b1, 1'b1);
            if (c >= ST) begin
                check("b2b valid", {15'd0, obs_v}, 16'd1);
                check("b2b sum", {8'd0, obs_sum}, 16'(c - ST + 3));
            end
        end
        check("b2b count", 16'(got_q.size()), 16'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check("b2b order", {7'd0, got_q[i]}, 16'(i + 3));

        // Stall with three operands
        got_q.delete();
        step(1'b1, 8'd10, 8'd1, 1'b0, 1'b0);
        step(1'b1, 8'd20, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd30, 8'd3, 1'b0, 1'b0);
            check("stall in_ready", {15'd0, obs_rdy}, 16'd0);
            check("stall sum", {8'd0, obs_sum}, 16'd11);
        end
        step(1'b1, 8'd30, 8'd3, 1'b0, 1'b1);
        for (int i = 0; i < 10 && got_q.size() < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        check("stall count", 16'(got_q.size()), 16'd3);
        if (got_q.size() == 3) begin
            check("stall r0", {7'd0, got_q[0]}, 16'd11);
            check("stall r1", {7'd0, got_q[1]}, 16'd22);
            check("stall r2", {7'd0, got_q[2]}, 16'd33);
        end

        // Random stream against the model
        repeat (300) begin
            step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        repeat (ST + 2) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Asynchronous reset with results in flight
        step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
        step(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        check("pre-reset valid", {15'd0, out_valid}, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async out_valid", {15'd0, out_valid}, 16'd0);
        check("async in_ready", {15'd0, in_ready}, 16'd1);
        check("async sum", {8'd0, sum}, 16'd0);
        check("async cout", {15'd0, cout}, 16'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held reset valid", {15'd0, out_valid}, 16'd0);
        #2;
        rst = 1'b1;
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h33, 8'h11, 1'b0, 1'b1);
        for (int k = 1; k <= ST; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (k == ST) begin
                check("post-reset valid", {15'd0, obs_v}, 16'd1);
                check("post-reset sum", {8'd0, obs_sum}, 16'h44);
            end
        end

        // Carry ripple across all slice boundaries at 2, 4 and 8 stages
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (k == ST) check("ripple2", {6'd0, obs_v, obs_cout, obs_sum}, 16'h0300);
            if (k == 3) check("ripple4 early", {15'd0, o4_v}, 16'd0);
            if (k == 4) check("ripple4", {6'd0, o4_v, o4_r}, 16'h0300);
            if (k == 7) check("ripple8 early", {15'd0, o8_v}, 16'd0);
            if (k == 8) check("ripple8", {6'd0, o8_v, o8_r}, 16'h0300);
        end

`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b1;
        step(1'b1, 8'd5, 8'd7, 1'b0, 1'b1);
        for (int k = 1; k <= ST; k++) step(1'b0, '0, '0, 1'b0, 1'b1);
        check("sub 5-7", {7'd0, obs_cout, obs_sum}, 16'd254);
        step(1'b1, 8'd7, 8'd5, 1'b0, 1'b1);
        for (int k = 1; k <= ST; k++) step(1'b0, '0, '0, 1'b0, 1'b1);
        check("sub 7-5", {7'd0, obs_cout, obs_sum}, 16'h102);
        sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
